// File: rtl/instrumented_adder_meter_pkg.sv
// Shared types and constants for the instrumented adder measurement sequencer.
package instr_adder_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        RUN,
        DRAIN,
        DONE
    } state_e;

    // Cycles with the ring gated off while the synchroniser and edge detector empty.
    localparam int DRAIN_CYCLES = 3;
    localparam int SYNC_STAGES  = 2;

endpackage

// File: rtl/instrumented_adder_meter_if.sv
// Control/status bus between the LA/Wishbone register block and the meter.
interface instrumented_adder_meter_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 32,
    parameter int WIN_W = 32
);
    logic                     start;
    logic                     abort;
    logic [3:0]               ch_sel;
    logic [WIDTH-1:0]         a_value;
    logic [WIDTH-1:0]         b_value;
    logic [$clog2(WIDTH)-1:0] ring_idx;
    logic [WIN_W-1:0]         window_cycles;
    logic                     busy;
    logic                     done;
    logic                     err;
    logic [CNT_W-1:0]         count;
    logic                     overflow;

    modport master (
        output start, abort, ch_sel, a_value, b_value, ring_idx, window_cycles,
        input  busy, done, err, count, overflow
    );

    modport slave (
        input  start, abort, ch_sel, a_value, b_value, ring_idx, window_cycles,
        output busy, done, err, count, overflow
    );
endinterface

// File: rtl/instrumented_adder_meter_osc_edge_counter.sv
// Synchronises one ring output, detects rising edges and counts them with saturation.
module osc_edge_counter
    import instr_adder_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             clr,
    input  logic             en,
    input  logic             osc,
    output logic [CNT_W-1:0] count,
    output logic             ovf
);
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   ovf_q, ovf_d;
    logic                   edge_seen;

    // Synchroniser and edge history run every cycle so a channel switch settles before counting.
    always_comb begin
        sync_d    = {sync_q[SYNC_STAGES-2:0], osc};
        prev_d    = sync_q[SYNC_STAGES-1];
        edge_seen = sync_q[SYNC_STAGES-1] & ~prev_q;
        count_d   = count_q;
        ovf_d     = ovf_q;
        if (clr) begin
            count_d = '0;
            ovf_d   = 1'b0;
        end else if (en && edge_seen) begin
            // An edge arriving at full scale is lost, which is what overflow reports.
            if (&count_q) ovf_d = 1'b1;
            else          count_d = count_q + CNT_W'(1);
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            sync_q  <= '0;
            prev_q  <= 1'b0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            prev_q  <= prev_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    assign count = count_q;
    assign ovf   = ovf_q;
endmodule

// File: rtl/instrumented_adder_meter.sv
// Measurement sequencer: drives adder operands, selects the ring tap, gates one ring
// for a programmable window and counts its edges.
//
//   state | meaning
//   IDLE  | waiting for start; operands held, ring off
//   SETUP | operands settling, tap selected, ring off
//   RUN   | selected ring enabled for window_cycles cycles
//   DRAIN | ring off, edges still in the synchroniser are counted
//   DONE  | one-cycle completion pulse
module instrumented_adder_meter
    import instr_adder_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 32,
    parameter int WIN_W  = 32,
    parameter int SETTLE = 4
) (
    input  logic                      wb_clk_i,
    input  logic                      wb_rst_i,
    instrumented_adder_meter_if.slave ctl,
    input  logic [NUM_CH-1:0]         osc_in,
    output logic [WIDTH-1:0]          a_input,
    output logic [WIDTH-1:0]          b_input,
    output logic [WIDTH-1:0]          ring_bit_b,
    output logic [NUM_CH-1:0]         osc_en
);
    localparam int IDX_W = $clog2(WIDTH);

    state_e           state_q, state_d;
    logic [3:0]       ch_q, ch_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WIN_W-1:0] win_q, win_d;
    logic [WIN_W-1:0] timer_q, timer_d;
    logic             err_q, err_d;
    logic             accept;
    logic             ch_ok;
    logic             osc_sel;
    logic             cnt_en;
    logic             tap_active;
    logic [CNT_W-1:0] cnt;
    logic             cnt_ovf;

    assign ch_ok = int'(ch_q) < NUM_CH;

    // Next-state, operand latching and the shared down-counting phase timer.
    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        a_d     = a_q;
        b_d     = b_q;
        idx_d   = idx_q;
        win_d   = win_q;
        timer_d = timer_q;
        err_d   = err_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (ctl.start && !ctl.abort) begin
                    accept  = 1'b1;
                    state_d = SETUP;
                    ch_d    = ctl.ch_sel;
                    a_d     = ctl.a_value;
                    b_d     = ctl.b_value;
                    idx_d   = ctl.ring_idx;
                    win_d   = ctl.window_cycles;
                    timer_d = WIN_W'(SETTLE - 1);
                    err_d   = 1'b0;
                end
            end
            SETUP: begin
                if (timer_q == '0) begin
                    if (!ch_ok) begin
                        state_d = DONE;
                        err_d   = 1'b1;
                    end else if (win_q == '0) begin
                        state_d = DRAIN;
                        timer_d = WIN_W'(DRAIN_CYCLES - 1);
                    end else begin
                        state_d = RUN;
                        timer_d = win_q - WIN_W'(1);
                    end
                end else begin
                    timer_d = timer_q - WIN_W'(1);
                end
            end
            RUN: begin
                if (timer_q == '0) begin
                    state_d = DRAIN;
                    timer_d = WIN_W'(DRAIN_CYCLES - 1);
                end else begin
                    timer_d = timer_q - WIN_W'(1);
                end
            end
            DRAIN: begin
                if (timer_q == '0) state_d = DONE;
                else               timer_d = timer_q - WIN_W'(1);
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (state_q != IDLE && ctl.abort) state_d = IDLE;
    end

    // State and latched request registers.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
            ch_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            idx_q   <= '0;
            win_q   <= '0;
            timer_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            a_q     <= a_d;
            b_q     <= b_d;
            idx_q   <= idx_d;
            win_q   <= win_d;
            timer_q <= timer_d;
            err_q   <= err_d;
        end
    end

    // Decode the ring enable, active-low tap select and the osc_in channel mux.
    always_comb begin
        tap_active = (state_q == SETUP) || (state_q == RUN) || (state_q == DRAIN);
        cnt_en     = (state_q == RUN) || (state_q == DRAIN);
        osc_sel    = 1'b0;
        osc_en     = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (int'(ch_q) == i) begin
                osc_sel   = osc_in[i];
                osc_en[i] = (state_q == RUN);
            end
        end
        ring_bit_b = '1;
        for (int i = 0; i < WIDTH; i++) begin
            if (tap_active && int'(idx_q) == i) ring_bit_b[i] = 1'b0;
        end
    end

    osc_edge_counter #(
        .CNT_W (CNT_W)
    ) u_counter (
        .wb_clk_i (wb_clk_i),
        .wb_rst_i (wb_rst_i),
        .clr      (accept),
        .en       (cnt_en),
        .osc      (osc_sel),
        .count    (cnt),
        .ovf      (cnt_ovf)
    );

    assign a_input      = a_q;
    assign b_input      = b_q;
    assign ctl.busy     = (state_q != IDLE);
    assign ctl.done     = (state_q == DONE);
    assign ctl.err      = err_q;
    assign ctl.count    = cnt;
    assign ctl.overflow = cnt_ovf;
endmodule

// File: tb/tb_instrumented_adder_meter.sv
// Bench for instrumented_adder_meter: table vectors, randomized runs, and hand sequences
// for saturation, abort and mid-measurement reset.
`timescale 1ns/1ps
module tb_instrumented_adder_meter;
    localparam int NUM_CH = 4;
    localparam int SETTLE = 4;
    localparam int DRAIN  = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    instrumented_adder_meter_if #(.WIDTH(32), .CNT_W(32), .WIN_W(32)) if_m ();
    instrumented_adder_meter_if #(.WIDTH(32), .CNT_W(4),  .WIN_W(32)) if_s ();

    logic [NUM_CH-1:0] osc_m = '0, osc_s = '0;
    logic [NUM_CH-1:0] osc_en_m, osc_en_s;
    logic [31:0]       a_in_m, b_in_m, ring_m, a_in_s, b_in_s, ring_s;

    instrumented_adder_meter #(.WIDTH(32), .NUM_CH(NUM_CH), .CNT_W(32), .WIN_W(32), .SETTLE(SETTLE)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .ctl(if_m), .osc_in(osc_m),
        .a_input(a_in_m), .b_input(b_in_m), .ring_bit_b(ring_m), .osc_en(osc_en_m));

    instrumented_adder_meter #(.WIDTH(32), .NUM_CH(NUM_CH), .CNT_W(4), .WIN_W(32), .SETTLE(SETTLE)) dut_s (
        .wb_clk_i(clk), .wb_rst_i(rst), .ctl(if_s), .osc_in(osc_s),
        .a_input(a_in_s), .b_input(b_in_s), .ring_bit_b(ring_s), .osc_en(osc_en_s));

    // Ring model: a ring only oscillates while enabled, toggling every half_p enabled cycles.
    int half_p = 4;
    int ph_m[NUM_CH], ph_s[NUM_CH], rises_m[NUM_CH], rises_s[NUM_CH];
    initial begin
        for (int c = 0; c < NUM_CH; c++) begin
            ph_m[c] = 0; ph_s[c] = 0; rises_m[c] = 0; rises_s[c] = 0;
        end
    end
    always @(posedge clk) begin
        #1;
        for (int c = 0; c < NUM_CH; c++) begin
            if (osc_en_m[c]) begin
                ph_m[c]++;
                if (ph_m[c] >= half_p) begin
                    ph_m[c] = 0; osc_m[c] = ~osc_m[c];
                    if (osc_m[c]) rises_m[c]++;
                end
            end
            if (osc_en_s[c]) begin
                ph_s[c]++;
                if (ph_s[c] >= half_p) begin
                    ph_s[c] = 0; osc_s[c] = ~osc_s[c];
                    if (osc_s[c]) rises_s[c]++;
                end
            end
        end
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    function automatic int ref_lat(input int ch, input int win);
        if (ch >= NUM_CH) return SETTLE + 1;
        return SETTLE + win + DRAIN + 1;
    endfunction

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    // One full measurement on the 32-bit-counter instance, with a busy-time start pulse.
    task automatic measure(input string tag, input int ch, input int win, input int hp,
                           input int ridx, input int lo, input int hi,
                           input bit exp_err, input int exp_lat);
        logic [31:0] a, b, oh;
        int base, done_k, n_done, en_cyc, bad_en, a_bad, ring_bad, exp_cnt, busy_after;
        a = $urandom; b = $urandom;
        half_p = hp;
        base = (ch < NUM_CH) ? rises_m[ch] : 0;
        oh = (ch < NUM_CH) ? (32'd1 << ch) : 32'd0;
        done_k = -1; n_done = 0; en_cyc = 0; bad_en = 0; a_bad = 0; ring_bad = 0; busy_after = -1;
        if_m.start = 1'b1; if_m.ch_sel = 4'(ch); if_m.a_value = a; if_m.b_value = b;
        if_m.ring_idx = 5'(ridx); if_m.window_cycles = 32'(win);
        for (int k = 1; k <= exp_lat + 3; k++) begin
            cyc();
            if_m.start = (k == 2);
            if (k == 2) if_m.a_value = ~a;
            if (osc_en_m != '0) begin
                if (32'(osc_en_m) == oh) en_cyc++;
                else bad_en++;
            end
            if (if_m.done === 1'b1) begin
                n_done++;
                if (done_k < 0) done_k = k;
            end
            if (a_in_m !== a || b_in_m !== b) a_bad++;
            if (k <= SETTLE && ring_m !== ~(32'd1 << ridx)) ring_bad++;
            if (k == exp_lat + 1) busy_after = int'(if_m.busy);
        end
        exp_cnt = (ch < NUM_CH) ? rises_m[ch] - base : 0;
        chk({tag, " done_latency"}, 64'(done_k), 64'(exp_lat));
        chk({tag, " done_pulses"}, 64'(n_done), 64'd1);
        chk({tag, " osc_en_cycles"}, 64'(en_cyc), exp_err ? 64'd0 : 64'(win));
        chk({tag, " osc_en_wrong_bit"}, 64'(bad_en), 64'd0);
        chk({tag, " err"}, 64'(if_m.err), 64'(exp_err));
        chk({tag, " count"}, 64'(if_m.count), 64'(exp_cnt));
        chk_range({tag, " count_range"}, int'(if_m.count), lo, hi);
        chk({tag, " overflow"}, 64'(if_m.overflow), 64'd0);
        chk({tag, " operands_held"}, 64'(a_bad), 64'd0);
        chk({tag, " ring_tap"}, 64'(ring_bad), 64'd0);
        chk({tag, " busy_after_done"}, 64'(busy_after), 64'd0);
        chk({tag, " ring_idle"}, 64'(ring_m), 64'hFFFF_FFFF);
    endtask

    typedef struct {
        int ch; int win; int hp; int ridx; int lo; int hi; bit err; int lat;
    } vec_t;

    initial begin
        vec_t tbl[5];
        int base, done_k, n_done, bad, cnt_at_abort, exp_cnt;
        tbl[0] = '{1, 100, 4,  7, 12, 13, 1'b0, 108};
        tbl[1] = '{0,   0, 2,  0,  0,  0, 1'b0,   8};
        tbl[2] = '{5,  30, 1, 31,  0,  0, 1'b1,   5};
        tbl[3] = '{3,  10, 1, 15,  5,  5, 1'b0,  18};
        tbl[4] = '{2,   1, 1,  3,  1,  1, 1'b0,   9};

        if_m.start = 0; if_m.abort = 0; if_m.ch_sel = 0; if_m.a_value = 0; if_m.b_value = 0;
        if_m.ring_idx = 0; if_m.window_cycles = 0;
        if_s.start = 0; if_s.abort = 0; if_s.ch_sel = 0; if_s.a_value = 0; if_s.b_value = 0;
        if_s.ring_idx = 0; if_s.window_cycles = 0;

        rst = 1'b1;
        repeat (3) cyc();
        rst = 1'b0;
        chk("reset ring_bit_b", 64'(ring_m), 64'hFFFF_FFFF);
        chk("reset osc_en", 64'(osc_en_m), 64'd0);
        chk("reset count", 64'(if_m.count), 64'd0);
        chk("reset busy", 64'(if_m.busy), 64'd0);
        chk("reset done_err_ovf", {61'd0, if_m.done, if_m.err, if_m.overflow}, 64'd0);
        chk("reset a_input", 64'(a_in_m), 64'd0);

        for (int i = 0; i < 5; i++)
            measure($sformatf("vec%0d", i), tbl[i].ch, tbl[i].win, tbl[i].hp, tbl[i].ridx,
                    tbl[i].lo, tbl[i].hi, tbl[i].err, tbl[i].lat);

        for (int i = 0; i < 12; i++) begin
            int ch, win;
            ch  = $urandom_range(0, 5);
            win = $urandom_range(0, 40);
            measure($sformatf("rnd%0d", i), ch, win, $urandom_range(1, 5), $urandom_range(0, 31),
                    0, 100000, ch >= NUM_CH, ref_lat(ch, win));
        end

        // Saturation on the 4-bit counter instance.
        half_p = 1;
        base = rises_s[0];
        done_k = -1;
        if_s.start = 1; if_s.ch_sel = 0; if_s.window_cycles = 64; if_s.a_value = 32'h1234;
        for (int k = 1; k <= ref_lat(0, 64) + 2; k++) begin
            cyc();
            if_s.start = 0;
            if (if_s.done === 1'b1 && done_k < 0) done_k = k;
        end
        exp_cnt = rises_s[0] - base;
        chk("sat done_latency", 64'(done_k), 64'(ref_lat(0, 64)));
        chk("sat count", 64'(if_s.count), (exp_cnt > 15) ? 64'd15 : 64'(exp_cnt));
        chk("sat overflow", 64'(if_s.overflow), 64'(exp_cnt > 15));

        // Abort at RUN cycle 20 with a simultaneous start carrying new operands.
        half_p = 2;
        base = rises_m[2];
        n_done = 0; bad = 0;
        if_m.start = 1; if_m.ch_sel = 2; if_m.window_cycles = 50; if_m.a_value = 32'hA5A5_0001;
        for (int k = 1; k <= SETTLE + 20; k++) begin
            cyc();
            if_m.start = 0;
            if (if_m.done === 1'b1) n_done++;
        end
        if_m.abort = 1; if_m.start = 1; if_m.a_value = 32'h0BAD_0BAD;
        cyc();
        if_m.abort = 0; if_m.start = 0;
        chk("abort busy", 64'(if_m.busy), 64'd0);
        chk("abort osc_en", 64'(osc_en_m), 64'd0);
        chk("abort a_input", 64'(a_in_m), 64'hA5A5_0001);
        chk_range("abort partial_count", int'(if_m.count), 1, rises_m[2] - base);
        cnt_at_abort = int'(if_m.count);
        for (int k = 0; k < 10; k++) begin
            if (if_m.done === 1'b1) n_done++;
            if (if_m.busy !== 1'b0 || osc_en_m !== '0 || int'(if_m.count) != cnt_at_abort) bad++;
            cyc();
        end
        chk("abort no_done", 64'(n_done), 64'd0);
        chk("abort stays_idle", 64'(bad), 64'd0);

        // Reset in the middle of a run.
        n_done = 0;
        if_m.start = 1; if_m.ch_sel = 1; if_m.window_cycles = 30; if_m.a_value = 32'h7777;
        for (int k = 1; k <= 12; k++) begin
            cyc();
            if_m.start = 0;
        end
        rst = 1;
        cyc();
        rst = 0;
        chk("midrst busy", 64'(if_m.busy), 64'd0);
        chk("midrst osc_en", 64'(osc_en_m), 64'd0);
        chk("midrst count", 64'(if_m.count), 64'd0);
        chk("midrst a_input", 64'(a_in_m), 64'd0);
        chk("midrst ring_bit_b", 64'(ring_m), 64'hFFFF_FFFF);
        for (int k = 0; k < 40; k++) begin
            if (if_m.done === 1'b1) n_done++;
            cyc();
        end
        chk("midrst no_done", 64'(n_done), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
